fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the opcode decoder in the single-cycle NN CPU.
- Holds the PC and issues one read per instruction to instruction memory, which returns data after a variable latency.
- Latches the returned word and presents split fields (opcode, rs, rt, rd, sign-extended immediate) to the decoder and register file with a valid/ready handshake.
- Replaces simulation-only halt/illegal handling with hardware state: HALT stops fetching; illegal opcodes become NOP plus a sticky flag.

Parameters:
- ADDR_W, 8, PC / instruction memory word-address width.
- DATA_W, 16, width of sign-extended immediate output.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching; level-sampled.
- imem_req  output  1  one-cycle read strobe to instruction memory.
- imem_addr  output  ADDR_W  word address; equals pc.
- imem_rdata  input  32  instruction word; sampled only when imem_valid=1 in WAIT.
- imem_valid  input  1  read data valid.
- instr_valid  output  1  fields below are valid.
- instr_ready  input  1  downstream accepts the current instruction.
- opcode  output  4  IR[31:28], or 4'b0000 if illegal.
- rs  output  4  IR[27:24].
- rt  output  4  IR[23:20].
- rd  output  4  IR[19:16].
- imm  output  DATA_W  IR[15:0] sign-extended to DATA_W; truncated to low DATA_W bits if DATA_W<16.
- pc  output  ADDR_W  address of the instruction held in IR.
- halted  output  1  HALT retired; fetching stopped.
- illegal_op  output  1  sticky; set when an undefined opcode is fetched.

Behaviour:
- Reset (async): state=IDLE; pc=RESET_PC; IR=0; imem_req=0; instr_valid=0; halted=0; illegal_op=0. All field outputs are therefore 0.
- Legal opcodes: 0000 NOP, 0001 ADD, 1001 ADDI, 0010 MUL, 0011 SINN, 0100 MAC, 1110 LD, 1111 ST, 1011 HALT. Every other value is illegal.
- FSM states: IDLE, FETCH, WAIT, ISSUE, HALTED.
- IDLE: outputs quiet. Go to FETCH on the next edge when start=1.
- FETCH:
  - imem_req=1 for exactly this one cycle; imem_addr=pc.
  - Go to WAIT unconditionally.
- WAIT:
  - imem_req=0.
  - On the edge where imem_valid=1: IR<=imem_rdata; go to ISSUE.
  - Otherwise remain in WAIT. There is no timeout.
- ISSUE:
  - instr_valid=1. Fields are decoded combinationally from IR and stay stable while instr_ready=0.
  - Illegal opcode: opcode output forced to 0000. illegal_op sets on the first cycle of ISSUE and stays set until reset.
  - On instr_valid&&instr_ready:
    - If opcode is HALT: go to HALTED; pc is not incremented.
    - Else: pc<=pc+1, wrapping from 2^ADDR_W-1 to 0; go to FETCH.
- HALTED: instr_valid=0; imem_req=0; halted=1. Only reset exits; start is ignored.
- Minimum issue period: 3 cycles per instruction when memory latency is 1 cycle (FETCH, WAIT, ISSUE).
- imem_valid outside WAIT is ignored and does not modify IR.
- Asserting start while not in IDLE has no effect.
- Reset mid-operation (any state, including WAIT with a read outstanding): return to reset values immediately. A late imem_valid arriving after reset is ignored because the FSM is in IDLE.
- No branches or jumps: the PC only increments.
- The decoder sees a stable opcode for the full ISSUE interval. PCEn from the decoder connects to instr_ready.

Test Plan:
- Reset, start=1, 1-cycle memory latency, words at 0..2 = ADD(0x1123_0000), ADDI(0x9120_FFFC), NOP, all accepted immediately:
  - imem_req pulses at 3-cycle spacing with addr 0,1,2.
  - ADDI presents imm=0xFFFC (DATA_W=16); pc increments 0→1→2→3.
- Backpressure: hold instr_ready=0 for 5 cycles on MAC 0x4567_0000 → instr_valid and opcode=0100 stable for 5 cycles; no imem_req; pc unchanged.
- HALT 0xB000_0000 at addr 4, accepted:
  - Next cycle halted=1, instr_valid=0, pc stays 4.
  - No further imem_req for 20 cycles, even with start=1.
- Illegal opcode 0x5000_0000:
  - opcode output=0000 and illegal_op=1 in the ISSUE cycle.
  - Fetch continues at pc+1; illegal_op remains 1 until reset.
- Wrap and latency: ADDR_W=8, RESET_PC=0xFE, latency 4 cycles → addresses 0xFE, 0xFF, 0x00; each instruction is latched only on its imem_valid cycle.
- Async reset asserted mid-WAIT, then imem_valid pulses 1 cycle after release → state IDLE, IR=0, instr_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one read per instruction,
// latches the returned word and presents decoded fields with valid/ready.
// HALT stops fetching; undefined opcodes issue as NOP and set a sticky flag.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        opcode,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [3:0]        rd,
    output logic [DATA_W-1:0] imm,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal_op
);

    localparam logic [3:0] OpHalt = 4'b1011;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StIssue,
        StHalted
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic              imem_req_q;
    logic              instr_valid_q;
    logic              halted_q;
    logic              illegal_q;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b1001, 4'b0010, 4'b0011,
            4'b0100, 4'b1110, 4'b1111, 4'b1011: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    // Fetch sequencer; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_q          <= ADDR_W'(RESET_PC);
            ir_q          <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StFetch;
                        imem_req_q <= 1'b1;
                    end
                end
                StFetch: begin
                    // Strobe lasts exactly one cycle.
                    imem_req_q <= 1'b0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (imem_valid) begin
                        ir_q          <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= StIssue;
                        // Set on entry so the flag is visible in the first ISSUE cycle.
                        if (!is_legal(imem_rdata[31:28])) begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        if (ir_q[31:28] == OpHalt) begin
                            halted_q <= 1'b1;
                            state_q  <= StHalted;
                        end else begin
                            pc_q       <= pc_q + ADDR_W'(1);
                            imem_req_q <= 1'b1;
                            state_q    <= StFetch;
                        end
                    end
                end
                StHalted: begin
                    // Only reset leaves this state.
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Field decode straight from IR so it stays stable while ISSUE is stalled.
    always_comb begin
        opcode = is_legal(ir_q[31:28]) ? ir_q[31:28] : 4'b0000;
        rs     = ir_q[27:24];
        rt     = ir_q[23:20];
        rd     = ir_q[19:16];
        imm    = DATA_W'($signed(ir_q[15:0]));
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable memory model and
// a scoreboard of expected issued instructions and request addresses.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode, rs, rt, rd;
    logic [15:0] imm;
    logic [7:0]  pc;
    logic        halted;
    logic        illegal_op;

    // Second instance for PC wrap from 0xFE with slow memory.
    logic        rst_w, start_w, ready_w;
    logic        w_req, w_valid_in, w_instr_valid, w_halted, w_illegal;
    logic [7:0]  w_addr, w_pc;
    logic [31:0] w_rdata;
    logic [3:0]  w_opcode, w_rs, w_rt, w_rd;
    logic [15:0] w_imm;

    logic [31:0] mem [0:255];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    logic [39:0] exp_q [$];
    logic [7:0]  req_q [$];
    int          req_cyc_q [$];
    logic [39:0] mon_e;
    logic [7:0]  mon_a;

    // Memory model controls.
    int          lat = 1;
    logic        resp_en;
    logic        r_valid;
    logic [31:0] r_data;
    int          r_cnt = 0;
    logic [7:0]  r_addr;
    logic        man_valid;
    logic [31:0] man_data;
    logic        wr_valid;
    logic [31:0] wr_data;
    int          wr_cnt = 0;
    logic [7:0]  wr_addr;

    fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .pc(pc), .halted(halted), .illegal_op(illegal_op)
    );

    fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'hFE)) dut_w (
        .clk(clk), .reset(rst_w), .start(start_w),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .imem_valid(w_valid_in),
        .instr_valid(w_instr_valid), .instr_ready(ready_w),
        .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .imm(w_imm),
        .pc(w_pc), .halted(w_halted), .illegal_op(w_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign imem_valid = r_valid | man_valid;
    assign imem_rdata = man_valid ? man_data : r_data;
    assign w_valid_in = wr_valid;
    assign w_rdata    = wr_data;

    // Main memory: data valid 'lat' cycles after the request cycle.
    always @(posedge clk) begin
        r_valid <= 1'b0;
        if (r_cnt == 1) begin
            r_valid <= 1'b1;
            r_data  <= mem[r_addr];
        end
        if (r_cnt != 0) r_cnt <= r_cnt - 1;
        if (imem_req && resp_en) begin
            if (lat == 1) begin
                r_valid <= 1'b1;
                r_data  <= mem[imem_addr];
                r_cnt   <= 0;
            end else begin
                r_cnt  <= lat - 1;
                r_addr <= imem_addr;
            end
        end
    end

    // Wrap-instance memory: fixed latency of 4.
    always @(posedge clk) begin
        wr_valid <= 1'b0;
        if (wr_cnt == 1) begin
            wr_valid <= 1'b1;
            wr_data  <= mem[wr_addr];
        end
        if (wr_cnt != 0) wr_cnt <= wr_cnt - 1;
        if (w_req) begin
            wr_cnt  <= 3;
            wr_addr <= w_addr;
        end
    end

    function automatic logic [39:0] mk(input logic [7:0] a, input logic [31:0] w);
        logic [3:0] op;
        op = w[31:28];
        if (!(op inside {4'h0, 4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'hE, 4'hF, 4'hB})) op = 4'h0;
        return {a, op, w[27:24], w[23:20], w[19:16], w[15:0]};
    endfunction

    // Scoreboard: accepted instructions and memory requests.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL issue_extra: observed pc %h, required no issue", pc);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                assert ({pc, opcode, rs, rt, rd, imm} === mon_e) else begin
                    errors++;
                    $error("FAIL issue: observed %h required %h",
                           {pc, opcode, rs, rt, rd, imm}, mon_e);
                end
            end
        end
        if (!reset && imem_req) begin
            req_cyc_q.push_back(cyc);
            checks++;
            assert (req_q.size() != 0) else begin
                errors++;
                $error("FAIL req_extra: observed addr %h, required no request", imem_addr);
            end
            if (req_q.size() != 0) begin
                mon_a = req_q.pop_front();
                checks++;
                assert (imem_addr === mon_a) else begin
                    errors++;
                    $error("FAIL req_addr: observed %h required %h", imem_addr, mon_a);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        chk({tag, "_wait"}, 32'(instr_valid), 1);
    endtask

    task automatic wait_pc(input logic [7:0] target);
        int n = 0;
        while (pc !== target && n < 50) begin
            step(1);
            n++;
        end
        chk("wait_pc", 32'(pc), 32'(target));
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] w);
        mem[a] = w;
        exp_q.push_back(mk(a, w));
        req_q.push_back(a);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instr_ready = 1'b1; resp_en = 1'b1;
        man_valid = 1'b0; man_data = '0;
        rst_w = 1'b1; start_w = 1'b0; ready_w = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        step(2);

        // Reset values
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_fields", {opcode, rs, rt, rd, imm}, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal_op), 0);
        chk("rst_w_pc", 32'(w_pc), 32'hFE);

        // Straight-line program, 1-cycle memory
        push(8'd0, 32'h1123_0000);
        push(8'd1, 32'h9120_FFFC);
        push(8'd2, 32'h0000_0000);
        push(8'd3, 32'h4567_0000);
        push(8'd4, 32'hB000_0000);
        reset = 1'b0;
        start = 1'b1;
        wait_pc(8'd3);
        instr_ready = 1'b0;

        // Backpressure on MAC
        wait_valid("mac");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(instr_valid), 1);
            chk("bp_opcode", 32'(opcode), 4);
            chk("bp_pc", 32'(pc), 3);
            chk("bp_req", 32'(imem_req), 0);
            step(1);
        end
        instr_ready = 1'b1;
        step(1);

        // HALT
        wait_valid("halt");
        step(1);
        chk("halt_halted", 32'(halted), 1);
        chk("halt_valid", 32'(instr_valid), 0);
        chk("halt_pc", 32'(pc), 4);
        for (int i = 0; i < 20; i++) begin
            chk("halt_noreq", 32'(imem_req), 0);
            step(1);
        end
        chk("req_count", req_cyc_q.size(), 5);
        if (req_cyc_q.size() >= 3) begin
            chk("req_spacing0", req_cyc_q[1] - req_cyc_q[0], 3);
            chk("req_spacing1", req_cyc_q[2] - req_cyc_q[1], 3);
        end
        chk("p1_drained", exp_q.size(), 0);

        // Illegal opcode
        reset = 1'b1;
        #1;
        chk("rst2_halted", 32'(halted), 0);
        chk("rst2_pc", 32'(pc), 0);
        req_cyc_q.delete();
        push(8'd0, 32'h5000_0000);
        push(8'd1, 32'h2345_8001);
        push(8'd2, 32'hB000_0000);
        step(1);
        reset = 1'b0;
        step(1);
        chk("ill_before", 32'(illegal_op), 0);
        wait_valid("ill");
        chk("ill_opcode", 32'(opcode), 0);
        chk("ill_flag", 32'(illegal_op), 1);
        step(1);
        wait_valid("mul");
        chk("ill_sticky_mul", 32'(illegal_op), 1);
        chk("mul_imm", 32'(imm), 32'h8001);
        step(1);
        wait_valid("halt2");
        step(1);
        chk("halt2_halted", 32'(halted), 1);
        chk("ill_sticky_halt", 32'(illegal_op), 1);
        chk("p2_drained", exp_q.size(), 0);

        // Reset mid-WAIT, then a stale response
        reset = 1'b1;
        #1;
        chk("rst3_illegal", 32'(illegal_op), 0);
        resp_en = 1'b0;
        req_q.push_back(8'd0);
        step(1);
        reset = 1'b0;
        step(1);
        chk("mw_fetch_req", 32'(imem_req), 1);
        step(1);
        chk("mw_wait_req", 32'(imem_req), 0);
        start = 1'b0;
        reset = 1'b1;
        #1;
        chk("mw_pc", 32'(pc), 0);
        chk("mw_valid", 32'(instr_valid), 0);
        step(1);
        reset = 1'b0;
        step(1);
        man_valid = 1'b1;
        man_data = 32'h1123_0000;
        step(1);
        man_valid = 1'b0;
        chk("late_valid", 32'(instr_valid), 0);
        chk("late_ir", {opcode, rs, rt, rd, imm}, 0);
        chk("late_pc", 32'(pc), 0);
        step(3);
        chk("late_idle_valid", 32'(instr_valid), 0);
        chk("late_idle_req", 32'(imem_req), 0);

        // Wrap with 4-cycle latency on the second instance
        mem[8'hFE] = 32'h0000_0000;
        mem[8'hFF] = 32'h1123_0000;
        mem[8'h00] = 32'h9120_0005;
        mem[8'h01] = 32'hB000_0000;
        rst_w = 1'b0;
        start_w = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int n;
            logic [7:0] a;
            logic [3:0] eop;
            logic [15:0] eimm;
            a = 8'(8'hFE + k);
            eop = (k == 0) ? 4'h0 : (k == 1) ? 4'h1 : 4'h9;
            eimm = (k == 2) ? 16'h0005 : 16'h0000;
            n = 0;
            while (w_req !== 1'b1 && n < 50) begin
                step(1);
                n++;
            end
            chk("wrap_req", 32'(w_req), 1);
            chk("wrap_addr", 32'(w_addr), 32'(a));
            n = 0;
            step(1);
            n++;
            while (w_instr_valid !== 1'b1 && n < 50) begin
                step(1);
                n++;
            end
            chk("wrap_latency", n, 5);
            chk("wrap_pc", 32'(w_pc), 32'(a));
            chk("wrap_opcode", 32'(w_opcode), 32'(eop));
            chk("wrap_imm", 32'(w_imm), 32'(eimm));
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
